cpu_seq: RTL and testbench
==========================

CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; ports in order:
  CLK  in  1  clock, all state updates on rising edge
  RST_N  in  1  asynchronous active-low reset
  EN  in  1  run enable
  INST_CLASS  in  3  decoded class of IR: 0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP, 6 LUI, 7 ILLEGAL
  BR_TAKEN  in  1  branch compare result, valid in EXEC
  MEM_RDY  in  1  memory completes current request this cycle
  OP1_SEL  out  2  operand-1 mux select (OP1_SRC_PC / OP1_SRC_INST / OP1_SRC_RD)
  OP2_SEL  out  2  operand-2 select: 0 register, 1 immediate, 2 constant 4
  IR_WE  out  1  instruction register load
  PC_WE  out  1  PC load
  PC_SRC  out  1  0 PC+4, 1 ALU result
  REG_WE  out  1  register file write
  WB_SEL  out  2  0 ALU, 1 memory data, 2 PC+4
  MEM_REQ  out  1  memory request
  MEM_WE  out  1  memory write
  MEM_ADDR_SEL  out  1  0 PC, 1 ALU result
  TRAP  out  1  sticky fault flag
  STATE  out  3  current state, debug

Function
REQ-002 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; outputs combinational from state, latched class and MEM_RDY; all outputs 0 when not listed.
REQ-003 IDLE: EN=1 -> FETCH next cycle; else remain.
REQ-004 FETCH: MEM_REQ=1, MEM_ADDR_SEL=0; IR_WE=MEM_RDY; MEM_RDY=1 -> DECODE.
REQ-005 DECODE: one cycle; latch INST_CLASS into internal class register; ILLEGAL -> HALT; else -> EXEC.
REQ-006 EXEC OP1_SEL: OP1_SRC_RD for ALU_R/ALU_I/LOAD/STORE; OP1_SRC_PC for BRANCH/JUMP; OP1_SRC_INST for LUI.
REQ-007 EXEC OP2_SEL: 0 for ALU_R; 1 for ALU_I/LOAD/STORE/BRANCH/JUMP/LUI.
REQ-008 EXEC next: LOAD/STORE -> MEM; BRANCH -> PC_WE=1, PC_SRC=BR_TAKEN, then FETCH (IDLE if EN=0); others -> WB.
REQ-009 MEM: MEM_REQ=1, MEM_ADDR_SEL=1, MEM_WE=(class==STORE); OP1_SEL/OP2_SEL held at EXEC values; on MEM_RDY: STORE -> PC_WE=1, PC_SRC=0, then FETCH/IDLE per EN; LOAD -> WB.
REQ-010 WB: REG_WE=1, WB_SEL = 1 LOAD, 2 JUMP, else 0; PC_WE=1, PC_SRC=(class==JUMP); -> FETCH if EN else IDLE.
REQ-011 EN=0 mid-instruction SHALL NOT abort; instruction completes, then IDLE.
REQ-012 8-bit wait counter SHALL clear on entry to FETCH/MEM, increment each cycle MEM_REQ=1 and MEM_RDY=0; 255 consecutive wait cycles -> HALT, TRAP=1.
REQ-013 MEM_RDY and timeout in same cycle: MEM_RDY wins.
REQ-014 HALT: TRAP=1, all enables 0, exit only by reset.
REQ-015 MEM_RDY outside FETCH/MEM SHALL be ignored.

Reset
REQ-016 RST_N=0 SHALL immediately force IDLE, class=0, counter=0, TRAP=0; all outputs 0 (OP1_SEL = OP1_SRC_PC = 0), including mid-request deassertion of MEM_REQ.
REQ-017 First transition out of IDLE SHALL occur no earlier than the first rising edge after RST_N rises.

Structure
REQ-018 State encodings, INST_CLASS codes, OP1_SRC_*, OP2/WB select codes SHALL live in shared defs.v; no literals in RTL.
REQ-019 Single module, no sub-module; wait counter and class register internal.

Verification
REQ-020 ALU_R, MEM_RDY=1 on first request: IDLE->FETCH->DECODE->EXEC->WB->FETCH; EXEC OP1_SEL=OP1_SRC_RD, OP2_SEL=0; WB REG_WE=1, PC_WE=1, PC_SRC=0.
REQ-021 LOAD, MEM_RDY delayed 3 cycles in MEM: MEM_REQ=1, MEM_ADDR_SEL=1 for 4 cycles; then WB with WB_SEL=1; STORE same: MEM_WE=1, no WB, PC_WE in final MEM cycle.
REQ-022 BRANCH BR_TAKEN=1 -> EXEC PC_WE=1, PC_SRC=1, next FETCH; BR_TAKEN=0 -> PC_SRC=0.
REQ-023 INST_CLASS=7 -> DECODE->HALT, TRAP=1 held 100 cycles; RST_N low -> IDLE, TRAP=0.
REQ-024 MEM_RDY=0 held in FETCH -> HALT after 255 wait cycles; MEM_RDY=1 on cycle 255 -> DECODE, no TRAP.
REQ-025 RST_N asserted asynchronously in MEM -> MEM_REQ=0 before next edge, STATE=IDLE; EN=0 during EXEC of JUMP -> WB (WB_SEL=2, PC_SRC=1) then IDLE.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the multi-cycle CPU sequencer: states, instruction
// classes, datapath mux selects and the memory wait limit.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU_R   = 3'd0,
        CLS_ALU_I   = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_LUI     = 3'd6,
        CLS_ILLEGAL = 3'd7
    } inst_class_e;

    localparam logic [1:0] OP1_SRC_PC   = 2'd0;
    localparam logic [1:0] OP1_SRC_INST = 2'd1;
    localparam logic [1:0] OP1_SRC_RD   = 2'd2;

    localparam logic [1:0] OP2_SEL_REG  = 2'd0;
    localparam logic [1:0] OP2_SEL_IMM  = 2'd1;
    localparam logic [1:0] OP2_SEL_FOUR = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    localparam logic PC_SRC_PLUS4 = 1'b0;
    localparam logic PC_SRC_ALU   = 1'b1;

    localparam logic ADDR_SEL_PC  = 1'b0;
    localparam logic ADDR_SEL_ALU = 1'b1;

    // A wait cycle seen while the counter already holds this value is the 255th.
    localparam logic [7:0] WAIT_LIMIT = 8'd254;

    function automatic logic [1:0] op1_for(input inst_class_e cls);
        logic [1:0] sel;
        unique case (cls)
            CLS_BRANCH, CLS_JUMP: sel = OP1_SRC_PC;
            CLS_LUI:              sel = OP1_SRC_INST;
            default:              sel = OP1_SRC_RD;
        endcase
        return sel;
    endfunction

    function automatic logic [1:0] op2_for(input inst_class_e cls);
        return (cls == CLS_ALU_R) ? OP2_SEL_REG : OP2_SEL_IMM;
    endfunction

endpackage

// File: rtl/cpu_seq.sv
// Multi-cycle CPU control sequencer: steps fetch/decode/execute/memory/writeback
// and traps on illegal instructions or memory requests that never complete.
module cpu_seq
    import cpu_seq_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic [2:0] INST_CLASS,
    input  logic       BR_TAKEN,
    input  logic       MEM_RDY,
    output logic [1:0] OP1_SEL,
    output logic [1:0] OP2_SEL,
    output logic       IR_WE,
    output logic       PC_WE,
    output logic       PC_SRC,
    output logic       REG_WE,
    output logic [1:0] WB_SEL,
    output logic       MEM_REQ,
    output logic       MEM_WE,
    output logic       MEM_ADDR_SEL,
    output logic       TRAP,
    output logic [2:0] STATE
);

    state_e      state_q, state_d;
    inst_class_e class_q, class_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        trap_q, trap_d;
    logic        timeout;

    assign timeout = (wait_cnt_q == WAIT_LIMIT);

    always_comb begin
        state_d      = state_q;
        class_d      = class_q;
        trap_d       = trap_q;
        wait_cnt_d   = wait_cnt_q;
        OP1_SEL      = OP1_SRC_PC;
        OP2_SEL      = OP2_SEL_REG;
        IR_WE        = 1'b0;
        PC_WE        = 1'b0;
        PC_SRC       = PC_SRC_PLUS4;
        REG_WE       = 1'b0;
        WB_SEL       = WB_SEL_ALU;
        MEM_REQ      = 1'b0;
        MEM_WE       = 1'b0;
        MEM_ADDR_SEL = ADDR_SEL_PC;

        unique case (state_q)
            ST_IDLE: begin
                if (EN) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                MEM_REQ      = 1'b1;
                MEM_ADDR_SEL = ADDR_SEL_PC;
                IR_WE        = MEM_RDY;
                if (MEM_RDY)      state_d = ST_DECODE;
                else if (timeout) state_d = ST_HALT;
            end
            ST_DECODE: begin
                class_d = inst_class_e'(INST_CLASS);
                state_d = (inst_class_e'(INST_CLASS) == CLS_ILLEGAL) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                OP1_SEL = op1_for(class_q);
                OP2_SEL = op2_for(class_q);
                unique case (class_q)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    CLS_BRANCH: begin
                        PC_WE   = 1'b1;
                        PC_SRC  = BR_TAKEN;
                        state_d = EN ? ST_FETCH : ST_IDLE;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                MEM_REQ      = 1'b1;
                MEM_ADDR_SEL = ADDR_SEL_ALU;
                MEM_WE       = (class_q == CLS_STORE);
                OP1_SEL      = op1_for(class_q);
                OP2_SEL      = op2_for(class_q);
                if (MEM_RDY) begin
                    if (class_q == CLS_STORE) begin
                        PC_WE   = 1'b1;
                        PC_SRC  = PC_SRC_PLUS4;
                        state_d = EN ? ST_FETCH : ST_IDLE;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout) begin
                    state_d = ST_HALT;
                end
            end
            ST_WB: begin
                REG_WE  = 1'b1;
                PC_WE   = 1'b1;
                if (class_q == CLS_LOAD)      WB_SEL = WB_SEL_MEM;
                else if (class_q == CLS_JUMP) WB_SEL = WB_SEL_PC4;
                PC_SRC  = (class_q == CLS_JUMP) ? PC_SRC_ALU : PC_SRC_PLUS4;
                state_d = EN ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_HALT) trap_d = 1'b1;

        // Any state change (including MEM -> FETCH after a store) starts a fresh wait window.
        if (state_d != state_q)         wait_cnt_d = '0;
        else if (MEM_REQ && !MEM_RDY)   wait_cnt_d = wait_cnt_q + 8'd1;

        TRAP  = trap_q;
        STATE = state_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            class_q    <= CLS_ALU_R;
            wait_cnt_q <= '0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            class_q    <= class_d;
            wait_cnt_q <= wait_cnt_d;
            trap_q     <= trap_d;
        end
    end

endmodule

// File: tb/tb_cpu_seq.sv
// Scoreboard bench for cpu_seq: an instruction-level model queues the expected
// per-cycle control word and a negedge monitor compares it with the DUT.
module tb_cpu_seq;
    import cpu_seq_pkg::*;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] op1;
        logic [1:0] op2;
        logic       ir_we;
        logic       pc_we;
        logic       pc_src;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       trap;
    } out_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       EN = 1'b0;
    logic [2:0] INST_CLASS = 3'd0;
    logic       BR_TAKEN = 1'b0;
    logic       MEM_RDY = 1'b0;
    logic [1:0] OP1_SEL, OP2_SEL, WB_SEL;
    logic       IR_WE, PC_WE, PC_SRC, REG_WE, MEM_REQ, MEM_WE, MEM_ADDR_SEL, TRAP;
    logic [2:0] STATE;

    int    checks = 0;
    int    errors = 0;
    logic  rstnDrv = 1'b0;
    out_t  expQ[$];
    string nameQ[$];
    out_t  monExp, monAct;
    string monName;

    cpu_seq dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .INST_CLASS(INST_CLASS),
        .BR_TAKEN(BR_TAKEN), .MEM_RDY(MEM_RDY), .OP1_SEL(OP1_SEL),
        .OP2_SEL(OP2_SEL), .IR_WE(IR_WE), .PC_WE(PC_WE), .PC_SRC(PC_SRC),
        .REG_WE(REG_WE), .WB_SEL(WB_SEL), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
        .MEM_ADDR_SEL(MEM_ADDR_SEL), .TRAP(TRAP), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    function automatic out_t mk(input logic [2:0] st, input logic [1:0] op1, input logic [1:0] op2,
                                input logic irWe, input logic pcWe, input logic pcSrc,
                                input logic regWe, input logic [1:0] wbSel, input logic memReq,
                                input logic memWe, input logic addrSel, input logic trap);
        return '{st, op1, op2, irWe, pcWe, pcSrc, regWe, wbSel, memReq, memWe, addrSel, trap};
    endfunction

    function automatic out_t quiet(input logic [2:0] st, input logic trap);
        return mk(st, 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, trap);
    endfunction

    function automatic logic [2:0] r3();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic logic r1();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the control word the model expects for it.
    task automatic applyStimulus(input logic en, input logic [2:0] cls, input logic br,
                                 input logic rdy, input out_t e, input string name);
        @(posedge CLK);
        #1;
        RST_N = rstnDrv; EN = en; INST_CLASS = cls; BR_TAKEN = br; MEM_RDY = rdy;
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    always @(negedge CLK) begin
        if (expQ.size() > 0) begin
            monExp  = expQ.pop_front();
            monName = nameQ.pop_front();
            monAct  = {STATE, OP1_SEL, OP2_SEL, IR_WE, PC_WE, PC_SRC, REG_WE, WB_SEL,
                       MEM_REQ, MEM_WE, MEM_ADDR_SEL, TRAP};
            checkOutput(monName, 32'(monAct), 32'(monExp));
        end
    end

    // Hold reset for a couple of cycles, release it, and leave the DUT heading into FETCH.
    task automatic resetAndStart();
        rstnDrv = 1'b0;
        applyStimulus(1, r3(), r1(), r1(), quiet(ST_IDLE, 0), "reset_idle");
        applyStimulus(1, r3(), r1(), r1(), quiet(ST_IDLE, 0), "reset_idle");
        rstnDrv = 1'b1;
        applyStimulus(1, r3(), r1(), r1(), quiet(ST_IDLE, 0), "release_idle");
    endtask

    // One instruction from its first FETCH cycle to its final cycle.
    task automatic runInstr(input int cls, input int fw, input int mw, input logic br, input logic enEnd);
        logic [1:0] op1, op2, wbSel;
        logic       isStore;
        for (int k = 0; k < fw; k++)
            applyStimulus(enEnd, r3(), r1(), 0, mk(ST_FETCH, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "fetch_wait");
        applyStimulus(enEnd, r3(), r1(), 1, mk(ST_FETCH, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0), "fetch_rdy");
        applyStimulus(enEnd, 3'(cls), r1(), r1(), quiet(ST_DECODE, 0), "decode");
        if (cls == 7) return;

        op1 = (cls == 4 || cls == 5) ? OP1_SRC_PC : (cls == 6) ? OP1_SRC_INST : OP1_SRC_RD;
        op2 = (cls == 0) ? 2'd0 : 2'd1;
        isStore = (cls == 3);

        if (cls == 4) begin
            applyStimulus(enEnd, r3(), br, r1(), mk(ST_EXEC, op1, op2, 0, 1, br, 0, 0, 0, 0, 0, 0), "exec_branch");
        end else begin
            applyStimulus(enEnd, r3(), r1(), r1(), mk(ST_EXEC, op1, op2, 0, 0, 0, 0, 0, 0, 0, 0, 0), "exec");
            if (cls == 2 || cls == 3) begin
                for (int k = 0; k < mw; k++)
                    applyStimulus(enEnd, r3(), r1(), 0,
                                  mk(ST_MEM, op1, op2, 0, 0, 0, 0, 0, 1, isStore, 1, 0), "mem_wait");
                applyStimulus(enEnd, r3(), r1(), 1,
                              mk(ST_MEM, op1, op2, 0, isStore, 0, 0, 0, 1, isStore, 1, 0), "mem_rdy");
            end
            if (!isStore) begin
                wbSel = (cls == 2) ? 2'd1 : (cls == 5) ? 2'd2 : 2'd0;
                applyStimulus(enEnd, r3(), r1(), r1(),
                              mk(ST_WB, 0, 0, 0, 1, (cls == 5), 1, wbSel, 0, 0, 0, 0), "wb");
            end
        end
        if (!enEnd)
            applyStimulus(1, r3(), r1(), r1(), quiet(ST_IDLE, 0), "idle_after_en_low");
    endtask

    initial begin
        RST_N = 1'b0;
        EN = 1'b1;
        #2;
        checkOutput("reset_state_async", 32'({STATE, MEM_REQ, TRAP}), 32'({3'(ST_IDLE), 1'b0, 1'b0}));
        resetAndStart();

        runInstr(0, 0, 0, 0, 1);
        runInstr(2, 1, 3, 0, 1);
        runInstr(3, 0, 3, 0, 1);
        runInstr(4, 0, 0, 1, 1);
        runInstr(4, 2, 0, 0, 1);
        runInstr(5, 0, 0, 0, 0);
        runInstr(6, 0, 0, 0, 1);
        runInstr(1, 0, 0, 0, 0);
        runInstr(3, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++)
            runInstr(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), r1(), ($urandom_range(0, 3) != 0));

        // Ready on the 255th cycle of a fetch still wins over the timeout.
        runInstr(0, 254, 0, 0, 1);

        // 255 unanswered fetch cycles end in a trap.
        for (int k = 0; k < 255; k++)
            applyStimulus(1, r3(), r1(), 0, mk(ST_FETCH, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "fetch_timeout_wait");
        for (int k = 0; k < 3; k++)
            applyStimulus(1, r3(), r1(), r1(), quiet(ST_HALT, 1), "halt_timeout");
        resetAndStart();

        runInstr(7, 0, 0, 0, 1);
        for (int k = 0; k < 100; k++)
            applyStimulus(r1(), r3(), r1(), r1(), quiet(ST_HALT, 1), "halt_illegal");
        resetAndStart();

        // Asynchronous reset in the middle of a load's memory request.
        applyStimulus(1, r3(), 0, 1, mk(ST_FETCH, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0), "fetch_rdy");
        applyStimulus(1, 3'd2, 0, 0, quiet(ST_DECODE, 0), "decode");
        applyStimulus(1, r3(), 0, 0, mk(ST_EXEC, OP1_SRC_RD, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "exec");
        applyStimulus(1, r3(), 0, 0, mk(ST_MEM, OP1_SRC_RD, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0), "mem_wait");
        @(negedge CLK);
        #2;
        rstnDrv = 1'b0;
        RST_N = 1'b0;
        #1;
        checkOutput("async_reset_mem_req", 32'(MEM_REQ), 32'd0);
        checkOutput("async_reset_state", 32'(STATE), 32'(ST_IDLE));
        resetAndStart();
        runInstr(0, 0, 0, 0, 0);

        repeat (3) @(posedge CLK);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
